regfile_sequencer: RTL and testbench
====================================

Name: regfile_sequencer

Overview:
- Initiator-side access engine for the 16x32 register file (A read port, C write port).
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Drives the register file select, data and write lines across multiple cycles, then returns one response per command.
- Sits between the control unit and the register file; used for READ, WRITE, COPY and SWAP micro-operations.

Parameters:
DATA_W, 32, register data width
SEL_W, 4, register select width (2**SEL_W registers)

Ports:
in_clk  input  1  clock; all state changes on the rising edge
in_clr  input  1  asynchronous active-low reset
in_cmd_valid  input  1  command present
out_cmd_ready  output  1  sequencer can accept a command
in_cmd_op  input  2  00 READ, 01 WRITE, 10 COPY, 11 SWAP
in_cmd_ra  input  SEL_W  first register
in_cmd_rb  input  SEL_W  second register (COPY source, SWAP partner)
in_cmd_wdata  input  DATA_W  WRITE data
out_rsp_valid  output  1  response present
in_rsp_ready  input  1  consumer takes the response
out_rsp_data  output  DATA_W  response data
out_rf_Aselect  output  SEL_W  register file read select
in_rf_Adata  input  DATA_W  register file read data (combinational from Aselect)
out_rf_read  output  1  read strobe
out_rf_Cselect  output  SEL_W  register file write select
out_rf_Cdata  output  DATA_W  register file write data
out_rf_write  output  1  write enable; the register file captures on the rising edge
out_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (in_clr=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs and the tmp0/tmp1/cmd latches clear to 0.
  - out_rf_write and out_rf_read drop to 0 immediately, so an in-flight write is aborted.
  - out_rsp_valid=0.
- out_cmd_ready = (state==IDLE) & in_clr.
  - A command is accepted on an edge where in_cmd_valid & out_cmd_ready.
  - op, ra, rb and wdata are latched at acceptance; later input changes are ignored.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
  - RD_A: Aselect=ra.
  - RD_B: Aselect=rb.
  - In both RD states, out_rf_read=1 and in_rf_Adata is sampled into tmp0 (RD_A) or tmp1 (RD_B) at the edge ending the state.
  - WR_A: Cselect=ra, write=1.
  - WR_B: Cselect=rb, Cdata=tmp0, write=1.
- Sequences, one state per cycle, all registered outputs:
  - READ: IDLE→RD_A→RESP. rsp_data=tmp0.
  - WRITE: IDLE→WR_A (Cdata=wdata)→RESP. rsp_data=wdata.
  - COPY: IDLE→RD_B→WR_A (Cdata=tmp1)→RESP. rsp_data=tmp1.
  - SWAP: IDLE→RD_A→RD_B→WR_A (Cdata=tmp1)→WR_B (Cdata=tmp0)→RESP. rsp_data=tmp0, the old ra value.
- Latency from the accept edge to out_rsp_valid high:
  - READ: 2 edges.
  - WRITE: 2 edges.
  - COPY: 3 edges.
  - SWAP: 5 edges.
- RESP:
  - out_rsp_valid=1 and out_rsp_data hold stable until an edge with in_rsp_ready=1, then → IDLE.
  - No accept is possible in the same cycle, since ready=0 in RESP.
  - Back-to-back READ throughput is one command per 3 cycles.
- Register 0 is architectural zero:
  - Any write state targeting select 0 keeps out_rf_write=0. The state still consumes its cycle and the response is still issued.
  - Reads of register 0 pass through whatever the register file returns (0).
- SWAP with ra==rb: runs the full sequence; the register value is unchanged; rsp_data = that value.
- Outside RD states: out_rf_read=0 and out_rf_Aselect holds its last value.
- Outside WR states: out_rf_write=0; Cselect and Cdata hold their last values.
- Never assert read and write in the same cycle.
- in_rsp_ready outside RESP is ignored.
- out_busy=1 in every non-IDLE state, including RESP.

Test Plan:
- Reset then WRITE ra=3, wdata=0xDEADBEEF:
  - out_rf_write=1 with Cselect=3 for exactly one cycle.
  - Response 0xDEADBEEF after 2 edges.
  - A following READ ra=3 returns 0xDEADBEEF.
- COPY ra=5, rb=3 after the above:
  - Reg5=0xDEADBEEF; response 0xDEADBEEF at 3 edges.
  - Read strobe on Aselect=3 for one cycle, then write on Cselect=5.
- SWAP with reg2=0x11111111, reg7=0x22222222, ra=2, rb=7:
  - Afterwards reg2=0x22222222 and reg7=0x11111111.
  - Response 0x11111111 at 5 edges.
- WRITE ra=0, wdata=0x12345678:
  - out_rf_write stays 0; response 0x12345678.
  - READ ra=0 returns 0x00000000.
- Hold in_rsp_ready=0 for 4 cycles after a READ:
  - rsp_valid/rsp_data stay stable; out_cmd_ready=0 and a second valid command is not accepted.
  - The second command is accepted the cycle after ready returns to 1.
- Assert in_clr=0 mid-cycle during WR_A of a SWAP:
  - out_rf_write falls immediately; state becomes IDLE; rsp_valid=0.
  - out_cmd_ready=1 on the first cycle after release; the interrupted WR_B never occurs.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Command sequencer for a 16x32 register file: turns READ/WRITE/COPY/SWAP
// commands into multi-cycle read/write strobe sequences and returns one response each.
module regfile_sequencer #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              in_clk,
    input  logic              in_clr,
    input  logic              in_cmd_valid,
    output logic              out_cmd_ready,
    input  logic [1:0]        in_cmd_op,
    input  logic [SEL_W-1:0]  in_cmd_ra,
    input  logic [SEL_W-1:0]  in_cmd_rb,
    input  logic [DATA_W-1:0] in_cmd_wdata,
    output logic              out_rsp_valid,
    input  logic              in_rsp_ready,
    output logic [DATA_W-1:0] out_rsp_data,
    output logic [SEL_W-1:0]  out_rf_Aselect,
    input  logic [DATA_W-1:0] in_rf_Adata,
    output logic              out_rf_read,
    output logic [SEL_W-1:0]  out_rf_Cselect,
    output logic [DATA_W-1:0] out_rf_Cdata,
    output logic              out_rf_write,
    output logic              out_busy
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR_A,
        S_WR_B,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic [SEL_W-1:0]    r_ra;
    logic [SEL_W-1:0]    r_rb;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_tmp0;
    logic [DATA_W-1:0]   r_tmp1;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [SEL_W-1:0]    r_rf_aselect;
    logic                r_rf_read;
    logic [SEL_W-1:0]    r_rf_cselect;
    logic [DATA_W-1:0]   r_rf_cdata;
    logic                r_rf_write;

    // Register 0 is hard-wired zero, so a write aimed at it is suppressed.
    function automatic logic wr_allowed(input logic [SEL_W-1:0] sel);
        return (sel != '0);
    endfunction

    assign out_cmd_ready  = (r_state == S_IDLE) & in_clr;
    assign out_busy       = (r_state != S_IDLE);
    assign out_rsp_valid  = r_rsp_valid;
    assign out_rsp_data   = r_rsp_data;
    assign out_rf_Aselect = r_rf_aselect;
    assign out_rf_read    = r_rf_read;
    assign out_rf_Cselect = r_rf_cselect;
    assign out_rf_Cdata   = r_rf_cdata;
    assign out_rf_write   = r_rf_write;

    // Outputs are computed for the state being entered, so each strobe is
    // registered and lines up exactly with its state's cycle.
    always_ff @(posedge in_clk or negedge in_clr) begin
        if (!in_clr) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_ra         <= '0;
            r_rb         <= '0;
            r_wdata      <= '0;
            r_tmp0       <= '0;
            r_tmp1       <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rf_aselect <= '0;
            r_rf_read    <= 1'b0;
            r_rf_cselect <= '0;
            r_rf_cdata   <= '0;
            r_rf_write   <= 1'b0;
        end else begin
            r_rf_read  <= 1'b0;
            r_rf_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_cmd_valid) begin
                        r_op    <= in_cmd_op;
                        r_ra    <= in_cmd_ra;
                        r_rb    <= in_cmd_rb;
                        r_wdata <= in_cmd_wdata;
                        case (in_cmd_op)
                            OP_WRITE: begin
                                r_state      <= S_WR_A;
                                r_rf_cselect <= in_cmd_ra;
                                r_rf_cdata   <= in_cmd_wdata;
                                r_rf_write   <= wr_allowed(in_cmd_ra);
                            end
                            OP_COPY: begin
                                r_state      <= S_RD_B;
                                r_rf_aselect <= in_cmd_rb;
                                r_rf_read    <= 1'b1;
                            end
                            default: begin
                                r_state      <= S_RD_A;
                                r_rf_aselect <= in_cmd_ra;
                                r_rf_read    <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_A: begin
                    r_tmp0 <= in_rf_Adata;
                    if (r_op == OP_SWAP) begin
                        r_state      <= S_RD_B;
                        r_rf_aselect <= r_rb;
                        r_rf_read    <= 1'b1;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= in_rf_Adata;
                    end
                end
                S_RD_B: begin
                    r_tmp1       <= in_rf_Adata;
                    r_state      <= S_WR_A;
                    r_rf_cselect <= r_ra;
                    r_rf_cdata   <= in_rf_Adata;
                    r_rf_write   <= wr_allowed(r_ra);
                end
                S_WR_A: begin
                    if (r_op == OP_SWAP) begin
                        r_state      <= S_WR_B;
                        r_rf_cselect <= r_rb;
                        r_rf_cdata   <= r_tmp0;
                        r_rf_write   <= wr_allowed(r_rb);
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= (r_op == OP_WRITE) ? r_wdata : r_tmp1;
                    end
                end
                S_WR_B: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_tmp0;
                end
                S_RESP: begin
                    if (in_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: attached register file array, directed steps
// and randomized commands checked against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile_sequencer;

    logic        in_clk = 1'b0;
    logic        in_clr;
    logic        in_cmd_valid;
    logic        out_cmd_ready;
    logic [1:0]  in_cmd_op;
    logic [3:0]  in_cmd_ra;
    logic [3:0]  in_cmd_rb;
    logic [31:0] in_cmd_wdata;
    logic        out_rsp_valid;
    logic        in_rsp_ready;
    logic [31:0] out_rsp_data;
    logic [3:0]  out_rf_Aselect;
    logic [31:0] in_rf_Adata;
    logic        out_rf_read;
    logic [3:0]  out_rf_Cselect;
    logic [31:0] out_rf_Cdata;
    logic        out_rf_write;
    logic        out_busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] rf  [16] = '{default: 32'h0};
    logic [31:0] mdl [16] = '{default: 32'h0};
    logic [31:0] last_rsp;
    logic [3:0]  rd_q [$];
    logic [3:0]  wr_q [$];

    regfile_sequencer #(.DATA_W(32), .SEL_W(4)) dut (
        .in_clk        (in_clk),
        .in_clr        (in_clr),
        .in_cmd_valid  (in_cmd_valid),
        .out_cmd_ready (out_cmd_ready),
        .in_cmd_op     (in_cmd_op),
        .in_cmd_ra     (in_cmd_ra),
        .in_cmd_rb     (in_cmd_rb),
        .in_cmd_wdata  (in_cmd_wdata),
        .out_rsp_valid (out_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .out_rf_Aselect(out_rf_Aselect),
        .in_rf_Adata   (in_rf_Adata),
        .out_rf_read   (out_rf_read),
        .out_rf_Cselect(out_rf_Cselect),
        .out_rf_Cdata  (out_rf_Cdata),
        .out_rf_write  (out_rf_write),
        .out_busy      (out_busy)
    );

    always #5 in_clk = ~in_clk;

    assign in_rf_Adata = rf[out_rf_Aselect];
    always @(posedge in_clk) begin
        if (out_rf_write) rf[out_rf_Cselect] <= out_rf_Cdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rf();
        logic [15:0] mask;
        mask = '0;
        for (int i = 0; i < 16; i++) if (rf[i] !== mdl[i]) mask[i] = 1'b1;
        chk("rf_contents_mask", {16'h0, mask}, 32'h0);
    endtask

    // Issue one command, follow it to its response, and compare against the model.
    task automatic t_issue(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [31:0] wd);
        logic [31:0] a, b, exp_rsp;
        logic [3:0]  erd [$];
        logic [3:0]  ewr [$];
        int          exp_lat, edges;
        a = mdl[ra];
        b = mdl[rb];
        exp_lat = 2;
        exp_rsp = a;
        case (op)
            2'd0: begin exp_rsp = a; exp_lat = 2; erd.push_back(ra); end
            2'd1: begin
                exp_rsp = wd; exp_lat = 2;
                if (ra != 0) begin ewr.push_back(ra); mdl[ra] = wd; end
            end
            2'd2: begin
                exp_rsp = b; exp_lat = 3; erd.push_back(rb);
                if (ra != 0) begin ewr.push_back(ra); mdl[ra] = b; end
            end
            default: begin
                exp_rsp = a; exp_lat = 5; erd.push_back(ra); erd.push_back(rb);
                if (ra != 0) begin ewr.push_back(ra); mdl[ra] = b; end
                if (rb != 0) begin ewr.push_back(rb); mdl[rb] = a; end
            end
        endcase
        in_cmd_valid = 1'b1;
        in_cmd_op    = op;
        in_cmd_ra    = ra;
        in_cmd_rb    = rb;
        in_cmd_wdata = wd;
        chk("cmd_ready_idle", {31'h0, out_cmd_ready}, 32'h1);
        @(posedge in_clk); #1;
        in_cmd_valid = 1'b0;
        in_cmd_op    = 2'($urandom_range(0, 3));
        in_cmd_ra    = 4'($urandom_range(0, 15));
        in_cmd_rb    = 4'($urandom_range(0, 15));
        in_cmd_wdata = $urandom;
        rd_q.delete();
        wr_q.delete();
        edges = 1;
        while (out_rsp_valid !== 1'b1 && edges < 12) begin
            chk("read_write_exclusive", {31'h0, out_rf_read & out_rf_write}, 32'h0);
            if (out_rf_read) rd_q.push_back(out_rf_Aselect);
            if (out_rf_write) wr_q.push_back(out_rf_Cselect);
            @(posedge in_clk); #1;
            edges++;
        end
        chk("rsp_valid_seen", {31'h0, out_rsp_valid}, 32'h1);
        chk("rsp_latency", edges, exp_lat);
        chk("rsp_data", out_rsp_data, exp_rsp);
        chk("busy_in_resp", {31'h0, out_busy}, 32'h1);
        chk("ready_in_resp", {31'h0, out_cmd_ready}, 32'h0);
        chk("read_count", rd_q.size(), erd.size());
        chk("write_count", wr_q.size(), ewr.size());
        for (int i = 0; i < erd.size() && i < rd_q.size(); i++) chk("read_select", {28'h0, rd_q[i]}, {28'h0, erd[i]});
        for (int i = 0; i < ewr.size() && i < wr_q.size(); i++) chk("write_select", {28'h0, wr_q[i]}, {28'h0, ewr[i]});
        last_rsp = exp_rsp;
    endtask

    task automatic t_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge in_clk); #1;
            chk("hold_rsp_valid", {31'h0, out_rsp_valid}, 32'h1);
            chk("hold_rsp_data", out_rsp_data, last_rsp);
            chk("hold_cmd_ready", {31'h0, out_cmd_ready}, 32'h0);
        end
    endtask

    task automatic t_release();
        in_rsp_ready = 1'b1;
        @(posedge in_clk); #1;
        in_rsp_ready = 1'b0;
        chk("release_rsp_valid", {31'h0, out_rsp_valid}, 32'h0);
        chk("release_busy", {31'h0, out_busy}, 32'h0);
        chk("release_ready", {31'h0, out_cmd_ready}, 32'h1);
        chk_rf();
    endtask

    initial begin
        int wcnt;
        in_clr       = 1'b0;
        in_cmd_valid = 1'b0;
        in_cmd_op    = 2'd0;
        in_cmd_ra    = 4'd0;
        in_cmd_rb    = 4'd0;
        in_cmd_wdata = 32'h0;
        in_rsp_ready = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        in_rsp_ready = 1'b0;
        chk("reset_rsp_valid", {31'h0, out_rsp_valid}, 32'h0);
        chk("reset_rf_write", {31'h0, out_rf_write}, 32'h0);
        chk("reset_rf_read", {31'h0, out_rf_read}, 32'h0);
        chk("reset_busy", {31'h0, out_busy}, 32'h0);
        chk("reset_cmd_ready", {31'h0, out_cmd_ready}, 32'h0);
        chk("reset_rsp_data", out_rsp_data, 32'h0);
        chk("reset_cselect", {28'h0, out_rf_Cselect}, 32'h0);
        chk("reset_cdata", out_rf_Cdata, 32'h0);
        @(negedge in_clr or negedge in_clk);
        in_clr = 1'b1;
        @(posedge in_clk); #1;

        t_issue(2'd1, 4'd3, 4'd0, 32'hDEADBEEF); t_release();
        chk("reg3_written", rf[3], 32'hDEADBEEF);
        t_issue(2'd0, 4'd3, 4'd0, 32'h0); chk("read3_value", out_rsp_data, 32'hDEADBEEF); t_release();
        t_issue(2'd2, 4'd5, 4'd3, 32'h0); chk("copy_rsp", out_rsp_data, 32'hDEADBEEF); t_release();
        chk("reg5_copied", rf[5], 32'hDEADBEEF);
        t_issue(2'd1, 4'd2, 4'd0, 32'h11111111); t_release();
        t_issue(2'd1, 4'd7, 4'd0, 32'h22222222); t_release();
        t_issue(2'd3, 4'd2, 4'd7, 32'h0); chk("swap_rsp", out_rsp_data, 32'h11111111); t_release();
        chk("swap_reg2", rf[2], 32'h22222222);
        chk("swap_reg7", rf[7], 32'h11111111);
        t_issue(2'd1, 4'd0, 4'd0, 32'h12345678); chk("write0_rsp", out_rsp_data, 32'h12345678); t_release();
        t_issue(2'd0, 4'd0, 4'd0, 32'h0); chk("read0_rsp", out_rsp_data, 32'h0); t_release();

        // Response back-pressure with a second command waiting.
        t_issue(2'd0, 4'd2, 4'd0, 32'h0);
        in_cmd_valid = 1'b1;
        in_cmd_op    = 2'd1;
        in_cmd_ra    = 4'd9;
        in_cmd_rb    = 4'd0;
        in_cmd_wdata = 32'hCAFEF00D;
        t_hold(4);
        t_release();
        t_issue(2'd1, 4'd9, 4'd0, 32'hCAFEF00D); t_release();

        t_issue(2'd3, 4'd5, 4'd5, 32'h0); chk("swap_same_rsp", out_rsp_data, 32'hDEADBEEF); t_release();

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [3:0]  ra, rb;
            logic [31:0] wd;
            op = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            wd = $urandom;
            t_issue(op, ra, rb, wd);
            t_hold($urandom_range(0, 2));
            t_release();
        end

        // Asynchronous reset in the middle of a SWAP's first write cycle.
        mdl[2] = 32'hA5A5A5A5;
        t_issue(2'd1, 4'd2, 4'd0, 32'hA5A5A5A5); t_release();
        t_issue(2'd1, 4'd7, 4'd0, 32'h5A5A5A5A); t_release();
        in_cmd_valid = 1'b1;
        in_cmd_op    = 2'd3;
        in_cmd_ra    = 4'd2;
        in_cmd_rb    = 4'd7;
        @(posedge in_clk); #1;
        in_cmd_valid = 1'b0;
        repeat (2) begin @(posedge in_clk); #1; end
        chk("swap_wra_write", {31'h0, out_rf_write}, 32'h1);
        chk("swap_wra_cselect", {28'h0, out_rf_Cselect}, 32'h2);
        #2;
        in_clr = 1'b0;
        #1;
        chk("abort_write_low", {31'h0, out_rf_write}, 32'h0);
        chk("abort_rsp_valid", {31'h0, out_rsp_valid}, 32'h0);
        chk("abort_busy", {31'h0, out_busy}, 32'h0);
        chk("abort_ready_in_reset", {31'h0, out_cmd_ready}, 32'h0);
        @(negedge in_clk);
        in_clr = 1'b1;
        @(posedge in_clk); #1;
        chk("post_reset_ready", {31'h0, out_cmd_ready}, 32'h1);
        wcnt = 0;
        repeat (6) begin
            if (out_rf_write) wcnt++;
            @(posedge in_clk); #1;
        end
        chk("no_write_after_abort", wcnt, 0);
        chk_rf();
        t_issue(2'd0, 4'd7, 4'd0, 32'h0); chk("reg7_after_abort", out_rsp_data, 32'h5A5A5A5A); t_release();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
